// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of the shared 16-bit data bus.
// One requester holds the bus at a time. Its data is registered onto
// data_out once per beat. A tenure lasts at most MAX_BURST beats while
// others are waiting, so no requester can starve the rest. Every output
// is a flop, so there is no combinational path from req to grant.
module bus_arbiter #(
  parameter int BUS_SIZE  = 16,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*BUS_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [ID_W-1:0]             owner,
  output logic [BUS_SIZE-1:0]         data_out,
  output logic                        data_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [ID_W-1:0]    last_owner;
  logic [CNT_W-1:0]   cnt;

  logic               owner_req;
  logic [NUM_REQ-1:0] others;
  logic [BUS_SIZE-1:0] owner_data;
  logic               tenure_end;
  logic [ID_W-1:0]    pick_idle;
  logic [ID_W-1:0]    pick_others;
  logic [ID_W-1:0]    pick_release;

  // First set bit of mask, scanning last+1, last+2, ... and ending on last.
  // The loop runs backwards, so the assignment that survives is the one for
  // the earliest position in rotation order.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                              input logic [ID_W-1:0]    last);
    logic [NUM_REQ-1:0] shifted;
    int                 idx;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx     = (int'(last) + k) % NUM_REQ;
      shifted = mask >> idx;
      if (shifted[0]) rr_pick = ID_W'(idx);
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

  // Decode of the current tenure and the candidate next owners.
  // grant equals onehot(owner) whenever the FSM is in BUSY, so masking req
  // with grant gives req[owner] without a variable-index select.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a value on every path;
    // a path that leaves one unassigned makes the tool infer a latch.
    owner_req    = |(req & grant);
    others       = req & ~grant;
    owner_data   = BUS_SIZE'(req_data >> (int'(owner) * BUS_SIZE));
    tenure_end   = (cnt == CNT_W'(MAX_BURST - 1));
    pick_idle    = rr_pick(req, last_owner);
    pick_others  = rr_pick(others, owner);
    pick_release = rr_pick(req, owner);
  end

  // Arbitration FSM. Grant, owner and bus data are all registered here.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples pre-edge values, and the order of the statements does not
    // matter.
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      cnt        <= '0;
      last_owner <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          data_valid <= 1'b0;
          if (|req) begin
            owner <= pick_idle;
            grant <= onehot(pick_idle);
            cnt   <= '0;
            state <= BUSY;
          end
        end

        BUSY: begin
          if (owner_req) begin
            // Beat: capture the owner's slice onto the bus.
            data_out   <= owner_data;
            data_valid <= 1'b1;
            if (!tenure_end) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              // Hand off with no bubble when someone else is waiting.
              // Otherwise the tenure simply renews.
              if (|others) begin
                owner      <= pick_others;
                grant      <= onehot(pick_others);
                last_owner <= owner;
              end
            end
          end else begin
            // Release: no beat this edge, and data_out keeps its value.
            data_valid <= 1'b0;
            last_owner <= owner;
            cnt        <= '0;
            if (|req) begin
              owner <= pick_release;
              grant <= onehot(pick_release);
            end else begin
              grant <= '0;
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios for bus_arbiter.
// Inputs are driven and outputs are sampled on the falling edge.
module tb_bus_arbiter;

  localparam int BUS_SIZE = 16;
  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_REQ-1:0]          req;
  logic [BUS_SIZE-1:0]         slice [NUM_REQ];
  logic [NUM_REQ*BUS_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]          grant;
  logic [ID_W-1:0]             owner;
  logic [BUS_SIZE-1:0]         data_out;
  logic                        data_valid;

  int errors = 0;
  int checks = 0;

  assign req_data = {slice[3], slice[2], slice[1], slice[0]};

  always #5 clk = ~clk;

  bus_arbiter #(
    .BUS_SIZE(BUS_SIZE), .NUM_REQ(NUM_REQ), .ID_W(ID_W),
    .MAX_BURST(4), .CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant), .owner(owner), .data_out(data_out), .data_valid(data_valid)
  );

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) slice[i] = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++; $display("FAIL reset_grant: got %b want 0000", grant);
    end
    checks++;
    if (data_out !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %h want 0000", data_out);
    end
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", data_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      errors++; $display("FAIL reset_first_grant: got %b/%0d want 0001/0", grant, owner);
    end
    checks++;
    if (data_valid !== 1'b0) begin
      errors++; $display("FAIL reset_first_valid: got %b want 0", data_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    slice[2] = 16'hA5C3;
    req      = 4'b0100;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2 || data_valid !== 1'b0) begin
      errors++; $display("FAIL single_grant: got %b/%0d/%b want 0100/2/0", grant, owner, data_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 16'hA5C3 || grant !== 4'b0100) begin
        errors++;
        $display("FAIL single_beat%0d: got v=%b d=%h g=%b want v=1 d=a5c3 g=0100",
                 i, data_valid, data_out, grant);
      end
    end
  endtask

  task automatic test_fairness();
    logic [BUS_SIZE-1:0] exp_data;
    logic [NUM_REQ-1:0]  exp_grant;
    do_reset();
    slice[0] = 16'h1111; slice[1] = 16'h2222; slice[2] = 16'h3333; slice[3] = 16'h4444;
    req = 4'b1111;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL fair_first: got %b want 0001", grant);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_data  = slice[(k / 4) % 4];
      exp_grant = 4'b0001 << (((k + 1) / 4) % 4);
      checks++;
      if (data_valid !== 1'b1 || data_out !== exp_data || grant !== exp_grant) begin
        errors++;
        $display("FAIL fair_beat%0d: got v=%b d=%h g=%b want v=1 d=%h g=%b",
                 k, data_valid, data_out, grant, exp_data, exp_grant);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    slice[0] = 16'h0A0A; slice[1] = 16'hBEEF; slice[2] = 16'h5555; slice[3] = 16'hCAFE;
    req = 4'b1010;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010 || owner !== 2'd1) begin
      errors++; $display("FAIL early_rotation: got %b/%0d want 0010/1", grant, owner);
    end
    req = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 16'hBEEF || grant !== 4'b0010) begin
        errors++;
        $display("FAIL early_beat%0d: got v=%b d=%h g=%b want v=1 d=beef g=0010",
                 i, data_valid, data_out, grant);
      end
    end
    req = 4'b1001;
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b0 || grant !== 4'b1000 || data_out !== 16'hBEEF) begin
      errors++;
      $display("FAIL early_release: got v=%b g=%b d=%h want v=0 g=1000 d=beef",
               data_valid, grant, data_out);
    end
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 16'hCAFE || owner !== 2'd3) begin
      errors++;
      $display("FAIL early_new_owner: got v=%b d=%h o=%0d want v=1 d=cafe o=3",
               data_valid, data_out, owner);
    end
  endtask

  task automatic test_idle_return();
    do_reset();
    slice[3] = 16'hCAFE;
    req      = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 16'hCAFE) begin
      errors++; $display("FAIL idle_setup: got v=%b d=%h want v=1 d=cafe", data_valid, data_out);
    end
    req      = 4'b0000;
    slice[3] = 16'h9999;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0000 || data_valid !== 1'b0 || data_out !== 16'hCAFE) begin
        errors++;
        $display("FAIL idle_hold%0d: got g=%b v=%b d=%h want g=0000 v=0 d=cafe",
                 i, grant, data_valid, data_out);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    slice[2] = 16'h7777;
    req      = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 16'h7777) begin
      errors++; $display("FAIL midrst_setup: got v=%b d=%h want v=1 d=7777", data_valid, data_out);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || owner !== 2'd0 || data_out !== 16'h0000 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_zero: got g=%b o=%0d d=%h v=%b want all zero",
               grant, owner, data_out, data_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2) begin
      errors++; $display("FAIL midrst_regrant: got %b/%0d want 0100/2", grant, owner);
    end
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 16'h7777) begin
      errors++; $display("FAIL midrst_beat: got v=%b d=%h want v=1 d=7777", data_valid, data_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_early_release();
    test_idle_return();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
